// File: rtl/ccg_vector_sequencer.sv
// Exhaustive vector sequencer for a CCG-family combinational netlist: drives each vector,
// waits a settle interval, streams {vector, response} over valid/ready. MISR under CCG_SEQ_MISR_EN.
module ccg_vector_sequencer #(
  parameter int          NIN           = 5,
  parameter int          NOUT          = 14,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] SIG_SEED      = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NIN-1:0]       first_vec,
  input  logic [NIN-1:0]       last_vec,
  output logic [NIN-1:0]       dut_x,
  input  logic [NOUT-1:0]      dut_f,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NIN+NOUT-1:0]  rsp_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          signature,
  output logic [NIN:0]         vec_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_PUSH,
    S_DONE
  } state_t;

  // Out-of-range settle requests fall back to a single cycle.
  localparam int          SETTLE      = (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  state_t         state, state_next;
  logic [3:0]     settle_cnt;
  logic [NIN-1:0] last_q;
  logic           at_last;

  assign at_last = (dut_x == last_q);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_DRIVE;
      S_DRIVE:  if (settle_cnt == SETTLE_LAST) state_next = S_SAMPLE;
      S_SAMPLE: state_next = S_PUSH;
      S_PUSH:   if (rsp_ready) state_next = at_last ? S_DONE : S_DRIVE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_x      <= '0;
      last_q     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      settle_cnt <= '0;
      vec_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            last_q     <= last_vec;
            dut_x      <= first_vec;
            vec_count  <= '0;
            busy       <= 1'b1;
            settle_cnt <= '0;
          end
        end
        S_DRIVE: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
        end
        S_SAMPLE: begin
          rsp_data  <= {dut_x, dut_f};
          rsp_valid <= 1'b1;
        end
        S_PUSH: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            vec_count <= vec_count + 1'b1;
            if (!at_last) dut_x <= dut_x + 1'b1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CCG_SEQ_MISR_EN
  logic [15:0] sig_q;
  logic [15:0] sig_next;

  always_comb begin
    sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(dut_f);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            sig_q <= SIG_SEED;
    else if (state == S_IDLE && start)  sig_q <= SIG_SEED;
    else if (state == S_SAMPLE)         sig_q <= sig_next;
  end

  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_ccg_vector_sequencer.sv
// Directed self-checking bench for ccg_vector_sequencer; uses a stub netlist and a partial
// model of the CCG netlist (f3, f4, f11, f12). Honours CCG_SEQ_MISR_EN for signature expectations.
module tb_ccg_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_vec;
  logic [4:0]  last_vec;
  logic [4:0]  dut_x;
  logic [13:0] dut_f;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [18:0] rsp_data;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [5:0]  vec_count;

  int          checks = 0;
  int          errors = 0;
  logic        real_mode = 1'b0;
  logic [18:0] words[$];
  int          done_cnt = 0;

`ifdef CCG_SEQ_MISR_EN
  localparam logic [15:0] RESET_SIG = 16'hFFFF;
`else
  localparam logic [15:0] RESET_SIG = 16'h0000;
`endif

  ccg_vector_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_vec (first_vec),
    .last_vec  (last_vec),
    .dut_x     (dut_x),
    .dut_f     (dut_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] f_real(input logic [4:0] x);
    logic [13:0] f;
    f     = '0;
    f[2]  = ~x[1] & x[3];
    f[3]  = x[2];
    f[10] = ~x[2];
    f[11] = ~x[1] & x[3];
    return f;
  endfunction

  function automatic logic [13:0] f_stub(input logic [4:0] x);
    return {9'b0, x};
  endfunction

  always_comb dut_f = real_mode ? f_real(dut_x) : f_stub(dut_x);

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) words.push_back(rsp_data);
    if (done) done_cnt++;
  end

  function automatic logic [15:0] model_sig(input logic [4:0] first, input int n, input logic realm);
`ifdef CCG_SEQ_MISR_EN
    logic [15:0] s;
    logic [4:0]  v;
    logic [13:0] f;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      v = first + 5'(i);
      f = realm ? f_real(v) : f_stub(v);
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {2'b00, f};
    end
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_vec = f;
    last_vec  = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < budget) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL run_timeout: busy=%b after %0d cycles, required 0", busy, cycles);
    end
  endtask

  task automatic check_stub_words(input string name, input int base, input logic [4:0] first, input int n);
    logic [4:0]  v;
    logic [18:0] exp;
    checks++;
    if (words.size() - base != n) begin
      errors++;
      $display("FAIL %s_count: got %0d words, required %0d", name, words.size() - base, n);
    end
    for (int i = 0; i < n && base + i < words.size(); i++) begin
      v   = first + 5'(i);
      exp = {v, 9'b0, v};
      checks++;
      if (words[base + i] !== exp) begin
        errors++;
        $display("FAIL %s_word[%0d]: got %h, required %h", name, i, words[base + i], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rsp_ready = 1'b0; first_vec = '0; last_vec = '0;
    repeat (3) @(negedge clk);
    checks++; if (dut_x !== 5'd0)       begin errors++; $display("FAIL reset_dut_x: got %h, required 0", dut_x); end
    checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (rsp_data !== 19'd0)   begin errors++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (signature !== RESET_SIG) begin errors++; $display("FAIL reset_signature: got %h, required %h", signature, RESET_SIG); end
    checks++; if (vec_count !== 6'd0)   begin errors++; $display("FAIL reset_vec_count: got %0d, required 0", vec_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    int d0;
    int base;
    int cyc;
    rsp_ready = 1'b1;
    d0 = done_cnt;
    do_start(5'd0, 5'd31);
    n = 0;
    while (!(dut_x === 5'd5 && rsp_valid === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL midrun_reach_vec5: dut_x=%h, required 5", dut_x); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrun_busy: got %b, required 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrun_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (dut_x !== 5'd0)     begin errors++; $display("FAIL midrun_dut_x: got %h, required 0", dut_x); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses, required 0", done_cnt - d0); end
    base = words.size();
    do_start(5'd2, 5'd3);
    run_to_idle(100, cyc);
    check_stub_words("midrun_restart", base, 5'd2, 2);
    checks++; if (vec_count !== 6'd2) begin errors++; $display("FAIL midrun_restart_count: got %0d, required 2", vec_count); end
  endtask

  task automatic test_full_sweep_stub();
    int d0;
    int base;
    int cyc;
    logic [15:0] exp_sig;
    real_mode = 1'b0;
    rsp_ready = 1'b1;
    d0   = done_cnt;
    base = words.size();
    do_start(5'd0, 5'd31);
    run_to_idle(1000, cyc);
    check_stub_words("sweep", base, 5'd0, 32);
    checks++; if (vec_count !== 6'd32) begin errors++; $display("FAIL sweep_vec_count: got %0d, required 32", vec_count); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL sweep_done_pulses: got %0d, required 1", done_cnt - d0); end
    exp_sig = model_sig(5'd0, 32, 1'b0);
    checks++; if (signature !== exp_sig) begin errors++; $display("FAIL sweep_signature: got %h, required %h", signature, exp_sig); end
  endtask

  task automatic test_real_netlist();
    int base;
    int cyc;
    logic [4:0]  v;
    logic [18:0] exp;
    real_mode = 1'b1;
    rsp_ready = 1'b1;
    base = words.size();
    do_start(5'd0, 5'd31);
    run_to_idle(1000, cyc);
    checks++; if (cyc != 129) begin errors++; $display("FAIL real_run_cycles: got %0d, required 129", cyc); end
    checks++;
    if (words.size() - base != 32) begin
      errors++; $display("FAIL real_count: got %0d words, required 32", words.size() - base);
    end else begin
      for (int i = 0; i < 32; i++) begin
        v   = 5'(i);
        exp = {v, f_real(v)};
        checks++;
        if (words[base + i] !== exp) begin
          errors++; $display("FAIL real_word[%0d]: got %h, required %h", i, words[base + i], exp);
        end
      end
      checks++;
      if (words[base + 8][2] !== 1'b1 || words[base + 8][11] !== 1'b1) begin
        errors++; $display("FAIL real_v8_f3_f12: got f3=%b f12=%b, required 1 1", words[base + 8][2], words[base + 8][11]);
      end
    end
    real_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    int base;
    int cyc;
    rsp_ready = 1'b0;
    base = words.size();
    do_start(5'd3, 5'd4);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 50) begin errors++; $display("FAIL bp_valid_timeout: rsp_valid=%b, required 1", rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== {5'd3, 9'b0, 5'd3} || dut_x !== 5'd3 || vec_count !== 6'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h x=%h cnt=%0d, required 1 %h 3 0",
                 i, rsp_valid, rsp_data, dut_x, vec_count, {5'd3, 9'b0, 5'd3});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || vec_count !== 6'd1) begin
      errors++; $display("FAIL bp_handshake: got valid=%b cnt=%0d, required 0 1", rsp_valid, vec_count);
    end
    run_to_idle(100, cyc);
    check_stub_words("bp", base, 5'd3, 2);
    checks++; if (vec_count !== 6'd2) begin errors++; $display("FAIL bp_vec_count: got %0d, required 2", vec_count); end
  endtask

  task automatic test_wrap_and_single();
    int base;
    int cyc;
    logic [15:0] exp_sig;
    rsp_ready = 1'b1;
    base = words.size();
    do_start(5'd30, 5'd1);
    run_to_idle(200, cyc);
    check_stub_words("wrap", base, 5'd30, 4);
    checks++; if (vec_count !== 6'd4) begin errors++; $display("FAIL wrap_vec_count: got %0d, required 4", vec_count); end
    exp_sig = model_sig(5'd30, 4, 1'b0);
    checks++; if (signature !== exp_sig) begin errors++; $display("FAIL wrap_signature: got %h, required %h", signature, exp_sig); end
    base = words.size();
    do_start(5'd7, 5'd7);
    run_to_idle(100, cyc);
    check_stub_words("single", base, 5'd7, 1);
    checks++; if (vec_count !== 6'd1) begin errors++; $display("FAIL single_vec_count: got %0d, required 1", vec_count); end
  endtask

  task automatic test_start_while_busy();
    int base;
    int cyc;
    logic [15:0] exp_sig;
    rsp_ready = 1'b1;
    base = words.size();
    do_start(5'd0, 5'd3);
    repeat (3) @(negedge clk);
    do_start(5'd20, 5'd25);
    run_to_idle(200, cyc);
    check_stub_words("busy_start", base, 5'd0, 4);
    checks++; if (vec_count !== 6'd4) begin errors++; $display("FAIL busy_start_vec_count: got %0d, required 4", vec_count); end
    exp_sig = model_sig(5'd0, 4, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (signature !== exp_sig) begin errors++; $display("FAIL busy_start_signature: got %h, required %h", signature, exp_sig); end
    checks++; if (busy !== 1'b0 || vec_count !== 6'd4) begin errors++; $display("FAIL idle_hold: got busy=%b cnt=%0d, required 0 4", busy, vec_count); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_full_sweep_stub();
    test_real_netlist();
    test_backpressure();
    test_wrap_and_single();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
